// File: rtl/axi_mem_pkg.sv
// Shared burst encoding, FSM state types and beat geometry for the AXI burst SRAM slave.
package axi_mem_pkg;

    localparam int unsigned BYTES_PER_BEAT = 16;
    localparam int unsigned OFFSET_BITS    = 4;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axi_burst_sram_slave.sv
// AXI-style burst slave over a word-addressed SRAM; independent read and write FSMs,
// one 16-byte beat per handshake, out-of-range words read as zero and ignore writes.
module axi_burst_sram_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rlast,
    input  logic                    rready,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int IDX_W  = ADDR_WIDTH - OFFSET_BITS;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input burst_t burst);
        return (burst == FIXED) ? idx : idx + IDX_W'(1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_word(input logic [IDX_W-1:0] idx);
        return in_range(idx) ? mem[idx[MEM_AW-1:0]] : '0;
    endfunction

    // Holds the address-channel readies low until the first edge after reset release.
    logic out_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) out_en <= 1'b0;
        else       out_en <= 1'b1;
    end

    // ---------------- read channel ----------------
    rd_state_t        r_state, r_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_left;
    burst_t           r_burst;
    logic             ar_hs, r_hs;

    assign arready = out_en && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_BURST);
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_BURST;
            R_BURST: if (r_hs && rlast) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // rdata is prefetched one beat ahead so a handshake immediately exposes the next word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx   <= '0;
            r_left  <= '0;
            r_burst <= INCR;
            rdata   <= '0;
            rlast   <= 1'b0;
        end else if (ar_hs) begin
            r_idx   <= araddr[ADDR_WIDTH-1:OFFSET_BITS];
            r_left  <= arlen;
            r_burst <= burst_t'(arburst);
            rdata   <= read_word(araddr[ADDR_WIDTH-1:OFFSET_BITS]);
            rlast   <= (arlen == 8'd0);
        end else if (r_hs) begin
            if (rlast) begin
                rlast <= 1'b0;
            end else begin
                r_idx  <= next_idx(r_idx, r_burst);
                rdata  <= read_word(next_idx(r_idx, r_burst));
                r_left <= r_left - 8'd1;
                rlast  <= (r_left == 8'd1);
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t        w_state, w_state_nxt;
    logic [IDX_W-1:0] w_idx;
    burst_t           w_burst;
    logic             aw_hs, w_hs;

    assign awready = out_en && (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    // The burst length is taken from wlast alone; awlen is not tracked.
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && wlast) w_state_nxt = W_RESP;
            W_RESP:  if (bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_idx   <= '0;
            w_burst <= INCR;
        end else if (aw_hs) begin
            w_idx   <= awaddr[ADDR_WIDTH-1:OFFSET_BITS];
            w_burst <= burst_t'(awburst);
        end else if (w_hs) begin
            w_idx   <= next_idx(w_idx, w_burst);
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && in_range(w_idx)) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[w_idx[MEM_AW-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    logic unused_sigs;
    assign unused_sigs = ^{araddr[OFFSET_BITS-1:0], awaddr[OFFSET_BITS-1:0], arsize, awsize, awlen};

endmodule

// File: doc/axi_burst_sram_slave.md
AXI_BURST_SRAM_SLAVE -- requirements
Module: axi_burst_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, beat width in bits; 16 bytes per beat.
REQ-003 SHALL have parameter DEPTH, default 32, number of DATA_WIDTH words.
REQ-004 SHALL have ports: clk in 1, the single clock; rstn in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: arvalid in 1; arready out 1; araddr in ADDR_WIDTH; arlen in 8; arsize in 3; arburst in 2, the read address channel.
REQ-006 SHALL have ports: rvalid out 1; rdata out DATA_WIDTH; rlast out 1; rready in 1, the read data channel.
REQ-007 SHALL have ports: awvalid in 1; awready out 1; awaddr in ADDR_WIDTH; awlen in 8; awsize in 3; awburst in 2, the write address channel.
REQ-008 SHALL have ports: wvalid in 1; wready out 1; wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1, the write data channel.
REQ-009 SHALL have ports: bvalid out 1; bready in 1, the write response channel; no resp fields.
REQ-010 Storage SHALL be one word array named mem[0:DEPTH-1], word index = byte address >> 4, for testbench backdoor preload and check.

Function
REQ-011 Read FSM SHALL have states R_IDLE and R_BURST; arready = 1 only in R_IDLE.
REQ-012 On arvalid&&arready, SHALL latch index = araddr>>4, beat count = arlen+1 and burst type, and go to R_BURST.
REQ-013 rvalid SHALL rise the cycle after the AR handshake, with rdata = mem[index] registered.
REQ-014 rdata/rlast SHALL hold stable while rvalid && !rready.
REQ-015 With rready held at 1, SHALL deliver one beat per cycle, with no bubbles.
REQ-016 rlast SHALL be 1 only on beat arlen, i.e. the final beat.
REQ-017 After the rlast handshake, SHALL return to R_IDLE with rvalid = 0 and arready = 1 on the next cycle.
REQ-018 INCR and WRAP SHALL advance index by 1 per beat; FIXED SHALL hold index.
REQ-019 An index >= DEPTH SHALL return rdata = 0.
REQ-020 arsize/awsize SHALL be ignored; every beat is 16 bytes.
REQ-021 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready = 1 only in W_IDLE and wready = 1 only in W_DATA.
REQ-022 The AW handshake SHALL latch index and burst type and go to W_DATA.
REQ-023 Each W handshake SHALL write byte i of wdata into mem[index] where wstrb[i] = 1, then advance index per REQ-018.
REQ-024 A write to index >= DEPTH SHALL be dropped.
REQ-025 The burst SHALL end on the W handshake with wlast = 1, regardless of awlen; the FSM then goes to W_RESP with bvalid = 1.
REQ-026 bvalid SHALL hold until bready; the handshake returns the FSM to W_IDLE.
REQ-027 Read and write FSMs SHALL be independent and may be active concurrently.
REQ-028 A same-word write and read beat in the same cycle SHALL return pre-write data; a read beat issued in a later cycle SHALL see the new data.

Reset
REQ-029 While rstn = 0, SHALL drive arready, awready, wready, rvalid, rlast and bvalid to 0, drive rdata to 0, and put both FSMs in IDLE.
REQ-030 arready and awready SHALL go to 1 on the first clock edge after rstn deasserts.
REQ-031 Reset mid-burst SHALL abort the burst immediately with no further beats and no B response.
REQ-032 mem contents SHALL NOT be reset.

Structure
REQ-033 Package axi_mem_pkg SHALL hold the burst enum (FIXED=2'b00, INCR=2'b01, WRAP=2'b10), read/write state typedefs, and BYTES_PER_BEAT=16 and OFFSET_BITS=4.
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 Preload mem[4..7] with distinct words, AR araddr=64 arlen=3 INCR, rready=1 -> 4 beats on consecutive cycles, rdata = mem[4..7], rlast on 4th only, first rvalid one cycle after AR handshake.
REQ-036 Same read with rready toggled 1,0,0,1,... -> each beat held stable during stalls, data order unchanged, exactly 4 handshakes.
REQ-037 AW awaddr=192 awlen=3, 4 W beats, wstrb=16'hFFFF, wlast on 4th -> mem[12..15] updated, bvalid one cycle after last beat, held until bready.
REQ-038 Single write to word 12 with wstrb=16'h000F over prior all-ones -> bytes 0-3 new, bytes 4-15 remain 8'hFF.
REQ-039 Concurrent 4-beat read of word 4 and 4-beat write of word 12 -> both complete, correct data, neither channel stalls the other; read at araddr=1024 -> rdata = 0.
REQ-040 Assert rstn=0 after the 2nd read beat -> rvalid and rlast 0 immediately, arready=1 one edge after release, next AR served normally.
